// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external WIDTH-bit ALU between two valid/ready requesters
//   clk, rst_n                       clock, asynchronous active-low reset
//   req{0,1}_valid/ready/a/b/op      request channels (op: 00 ADD, 01 SUB, 10 NAND, 11 XOR)
//   rsp{0,1}_valid/ready/data/err    response channels (err = signed overflow, ADD/SUB only)
//   alu_in1, alu_in2, alu_op         registered operand drive to the ALU
//   alu_out, alu_err                 combinational ALU result and overflow
//   busy                             high whenever an operation is in flight
module alu_share_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data,
   output logic             rsp1_err,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_err,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nx;
   logic gid, last_grant, grant, accept, rsp_hs, rsp_err;
   logic [WIDTH-1:0] rsp_data;
   always_comb begin
      grant    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      accept   = state == IDLE && (req0_valid || req1_valid);
      rsp_hs   = state == RESP && (gid ? rsp1_ready : rsp0_ready);
      state_nx = state == IDLE ? (accept ? EXEC : IDLE) :
                 state == EXEC ? RESP : (rsp_hs ? IDLE : RESP);
   end
   // ready is gated by rst_n so it reads 0 while reset is held, even with valid high
   assign req0_ready = rst_n && state == IDLE && req0_valid && !grant;
   assign req1_ready = rst_n && state == IDLE && req1_valid && grant;
   assign rsp0_valid = state == RESP && !gid;
   assign rsp1_valid = state == RESP && gid;
   assign rsp0_data  = rsp_data;
   assign rsp1_data  = rsp_data;
   assign rsp0_err   = rsp_err;
   assign rsp1_err   = rsp_err;
   assign busy       = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gid        <= 1'b0;
         last_grant <= 1'b1;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_op     <= 2'b00;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            alu_in1 <= grant ? req1_a : req0_a;
            alu_in2 <= grant ? req1_b : req0_b;
            alu_op  <= grant ? req1_op : req0_op;
            gid     <= grant;
         end
         if (state == EXEC) begin
            rsp_data <= alu_out;
            // overflow is meaningless for logic ops, so mask whatever the ALU reports
            rsp_err  <= ~alu_op[1] & alu_err;
         end
         if (rsp_hs) last_grant <= gid;
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized and directed check of alu_share_arbiter against a transaction-level model
module tb_alu_share_arbiter;
   logic clk = 0, rst_n = 0;
   logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
   logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [1:0] req0_op = 0, req1_op = 0;
   logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy, alu_err;
   logic [3:0] rsp0_data, rsp1_data, alu_in1, alu_in2, alu_out;
   logic [1:0] alu_op;
   logic force_err = 0;
   int n_run = 0, n_fail = 0;
   bit v0, v1, last;
   logic [9:0] p0, p1;
   always #5 clk = ~clk;
   alu_share_arbiter #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out), .alu_err(alu_err),
      .busy(busy)
   );
   // ALU stub in the environment; force_err drives alu_err high regardless of opcode
   always_comb begin
      alu_out = alu_op == 2'b00 ? alu_in1 + alu_in2 : alu_op == 2'b01 ? alu_in1 - alu_in2 :
                alu_op == 2'b10 ? ~(alu_in1 & alu_in2) : alu_in1 ^ alu_in2;
      alu_err = force_err ||
                (alu_op == 2'b00 && alu_in1[3] == alu_in2[3] && alu_out[3] != alu_in1[3]) ||
                (alu_op == 2'b01 && alu_in1[3] != alu_in2[3] && alu_out[3] != alu_in1[3]);
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // reference result from signed/unsigned integer arithmetic on the request payload
   task automatic ref_alu(input logic [9:0] p, output logic [3:0] d, output bit ovf);
      int a, b, sa, sb, s;
      a = p[7:4]; b = p[3:0];
      sa = a > 7 ? a - 16 : a; sb = b > 7 ? b - 16 : b;
      case (p[9:8])
         2'd0: begin s = sa + sb; d = 4'((a + b) % 16); end
         2'd1: begin s = sa - sb; d = 4'((a - b + 16) % 16); end
         2'd2: begin s = 0; d = 4'(15 - (a & b)); end
         default: begin s = 0; d = 4'(a ^ b); end
      endcase
      ovf = s > 7 || s < -8;
   endtask
   task automatic drive();
      req0_valid = v0; {req0_op, req0_a, req0_b} = p0;
      req1_valid = v1; {req1_op, req1_a, req1_b} = p1;
   endtask
   // one full transaction from a negedge in IDLE; at least one of v0/v1 must be set
   task automatic txn(input int stall, input bit fe);
      bit g, ovf, ee;
      logic [9:0] p;
      logic [3:0] ed;
      g = (v0 && v1) ? !last : v1;
      p = g ? p1 : p0;
      ref_alu(p, ed, ovf);
      ee = p[9] ? 1'b0 : (fe || ovf);
      drive();
      force_err = fe;
      #1;
      chk("req0_ready_idle", req0_ready, v0 && !g);
      chk("req1_ready_idle", req1_ready, v1 && g);
      @(posedge clk); @(negedge clk);
      if (g) v1 = 0; else v0 = 0;
      drive();
      chk("busy_exec", busy, 1);
      chk("rsp_valid_exec", {rsp1_valid, rsp0_valid}, 0);
      chk("ready_exec", {req1_ready, req0_ready}, 0);
      chk("alu_drive", {alu_op, alu_in1, alu_in2}, p);
      @(posedge clk); @(negedge clk);
      for (int i = 0; i <= stall; i++) begin
         chk("rsp_valid", {rsp1_valid, rsp0_valid}, g ? 2'b10 : 2'b01);
         chk("rsp_data", g ? rsp1_data : rsp0_data, ed);
         chk("rsp_err", g ? rsp1_err : rsp0_err, ee);
         chk("ready_resp", {req1_ready, req0_ready}, 0);
         chk("busy_resp", busy, 1);
         if (i == stall) begin rsp0_ready = !g; rsp1_ready = g; end
         @(posedge clk); @(negedge clk);
      end
      rsp0_ready = 0; rsp1_ready = 0;
      chk("rsp_valid_done", {rsp1_valid, rsp0_valid}, 0);
      chk("busy_done", busy, 0);
      last = g;
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk(tag, {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, alu_in1, alu_in2, alu_op,
                rsp0_data, rsp1_data, rsp0_err, rsp1_err}, 0);
   endtask
   initial begin
      last = 1; v0 = 0; v1 = 0; p0 = 0; p1 = 0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset_state");
      rst_n = 1;
      @(negedge clk);
      v0 = 1; p0 = {2'd0, 4'b0111, 4'b0001};
      txn(0, 0);
      v1 = 1; p1 = {2'd1, 4'b0100, 4'b0011};
      txn(0, 0);
      v0 = 1; v1 = 1; p0 = {2'd2, 4'b1100, 4'b1010}; p1 = {2'd3, 4'b1100, 4'b1010};
      for (int i = 0; i < 6; i++) begin
         chk("alternate_grant", v0 && v1 && last == 1'(i % 2 == 0), 1);
         txn(0, 0);
         if (!v0) begin v0 = 1; p0 = {2'd2, 4'b1100, 4'b1010}; end
         if (!v1) begin v1 = 1; p1 = {2'd3, 4'b1100, 4'b1010}; end
      end
      p0 = {2'd0, 4'b0011, 4'b0010};
      txn(5, 0);
      txn(0, 0);
      v0 = 1; p0 = {2'd2, 4'b1111, 4'b0000};
      txn(0, 1);
      v0 = 1; p0 = {2'd0, 4'b0001, 4'b0001};
      txn(0, 1);
      for (int i = 0; i < 40; i++) begin
         if (!v0 && !v1) begin v0 = 1'($urandom_range(1)); v1 = !v0 || 1'($urandom_range(1)); end
         if (!v0 && $urandom_range(1) == 1) begin v0 = 1; p0 = 10'($urandom); end
         if (!v1 && $urandom_range(1) == 1) begin v1 = 1; p1 = 10'($urandom); end
         if (v0 && p0 == 0) p0 = 10'($urandom);
         if (v1 && p1 == 0) p1 = 10'($urandom);
         txn($urandom_range(3), $urandom_range(9) == 0);
      end
      v0 = 1; v1 = 0; p0 = {2'd0, 4'b0101, 4'b0101};
      drive();
      @(posedge clk); @(negedge clk);
      rst_n = 0;
      #1;
      chk_reset_outputs("reset_in_exec");
      @(negedge clk);
      rst_n = 1; v0 = 0; drive();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_rsp_after_reset", {rsp1_valid, rsp0_valid, busy}, 0);
      end
      last = 1; v0 = 1; v1 = 1; p0 = {2'd3, 4'b1010, 4'b0101}; p1 = {2'd1, 4'b0000, 4'b0001};
      txn(0, 0);
      chk("tie_after_reset_to_req0", v1, 1);
      txn(0, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
